// File: rtl/sof_frame_scheduler.sv
// SOF / low-speed keep-alive scheduler: owns the frame timer and 11-bit frame number and issues one write per frame.
// Define SOF_MISS_CNT_EN to add the saturating missed-frame counter (missCnt) and its clear input (missCntClr).
module sof_frame_scheduler #(
  parameter int SOF_PERIOD = 48000,
  parameter int TX_MARGIN  = 16,
  parameter int TIMER_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sofEnable,
  input  logic               sofSyncEn,
  input  logic               lowSpeedMode,
  input  logic               sendPacketArbiterGnt,
  input  logic               sendPacketRdy,
`ifdef SOF_MISS_CNT_EN
  input  logic               missCntClr,
  output logic [7:0]         missCnt,
`endif
  output logic               sendPacketArbiterReq,
  output logic               sendPacketWEn,
  output logic [3:0]         sendPacketPID,
  output logic [10:0]        frameNum,
  output logic [TIMER_W-1:0] sofTimer,
  output logic               sofSent
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SOF_PERIOD - 1);
  localparam logic [TIMER_W-1:0] TIMER_NEAR = TIMER_W'(SOF_PERIOD - 1 - TX_MARGIN);
  localparam logic [3:0]         PID_SOF        = 4'h5;
  localparam logic [3:0]         PID_KEEP_ALIVE = 4'h0;

  typedef enum logic [1:0] {WAIT_NEAR, WAIT_GNT, WAIT_NOW, FIN} state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [10:0]        frame_q, frame_d;
  logic               req_q, req_d;
  logic               wen_q, wen_d;
  logic [3:0]         pid_q, pid_d;
  logic               granted;
  logic               at_last;
  logic               at_near;

  assign granted = sendPacketArbiterGnt & sendPacketRdy;
  assign at_last = (timer_q == TIMER_LAST);
  assign at_near = (timer_q == TIMER_NEAR);

  // Sync only re-aligns the timer while no arbitration is in flight.
  always_comb begin
    if (!sofEnable) begin
      timer_d = '0;
    end else if (sofSyncEn && (state_q == WAIT_NEAR)) begin
      timer_d = TIMER_NEAR;
    end else if (at_last) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wen_d   = 1'b0;
    pid_d   = pid_q;
    frame_d = frame_q;
    if (!sofEnable) begin
      state_d = WAIT_NEAR;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        WAIT_NEAR: begin
          if (at_near) begin
            req_d   = 1'b1;
            state_d = WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (granted) begin
            if (at_last) begin
              wen_d   = 1'b1;
              pid_d   = lowSpeedMode ? PID_KEEP_ALIVE : PID_SOF;
              state_d = FIN;
            end else begin
              state_d = WAIT_NOW;
            end
          end else if (at_last) begin
            // Grant arrived too late for this boundary: the frame is lost but still counted.
            req_d   = 1'b0;
            frame_d = frame_q + 11'd1;
            state_d = WAIT_NEAR;
          end
        end
        WAIT_NOW: begin
          if (at_last) begin
            wen_d   = 1'b1;
            pid_d   = lowSpeedMode ? PID_KEEP_ALIVE : PID_SOF;
            state_d = FIN;
          end
        end
        FIN: begin
          req_d   = 1'b0;
          frame_d = frame_q + 11'd1;
          state_d = WAIT_NEAR;
        end
        default: state_d = WAIT_NEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_NEAR;
      timer_q <= '0;
      frame_q <= '0;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      frame_q <= frame_d;
      req_q   <= req_d;
      wen_q   <= wen_d;
      pid_q   <= pid_d;
    end
  end

  assign sendPacketArbiterReq = req_q;
  assign sendPacketWEn        = wen_q;
  assign sofSent              = wen_q;
  assign sendPacketPID        = pid_q;
  assign frameNum             = frame_q;
  assign sofTimer             = timer_q;

`ifdef SOF_MISS_CNT_EN
  logic [7:0] miss_cnt_q, miss_cnt_d;
  logic       missed;

  assign missed = sofEnable && (state_q == WAIT_GNT) && at_last && !granted;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (missCntClr) begin
      miss_cnt_d = '0;
    end else if (missed && (miss_cnt_q != 8'hFF)) begin
      miss_cnt_d = miss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign missCnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sof_frame_scheduler.sv
// Bench for sof_frame_scheduler (SOF_PERIOD=100, TX_MARGIN=10): vector table, hand sequences, random run vs. a frame-level model.
// Miss-counter ports and checks are included when SOF_MISS_CNT_EN is defined.
module tb_sof_frame_scheduler;
  localparam int P  = 100;
  localparam int M  = 10;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sofEnable = 1'b0;
  logic          sofSyncEn = 1'b0;
  logic          lowSpeedMode = 1'b0;
  logic          gnt = 1'b0;
  logic          rdy = 1'b0;
  logic          clr = 1'b0;
  logic          req, wen, sent;
  logic [3:0]    pid;
  logic [10:0]   fnum;
  logic [TW-1:0] tmr;
`ifdef SOF_MISS_CNT_EN
  logic [7:0]    mcnt;
`endif

  int errors = 0;
  int checks = 0;

  // Model: the arbitration window is open exactly while the request is high.
  int m_timer, m_frame, m_miss, m_pid;
  bit m_req, m_wen, m_granted;

  sof_frame_scheduler #(.SOF_PERIOD(P), .TX_MARGIN(M), .TIMER_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .sofEnable(sofEnable),
    .sofSyncEn(sofSyncEn),
    .lowSpeedMode(lowSpeedMode),
    .sendPacketArbiterGnt(gnt),
    .sendPacketRdy(rdy),
`ifdef SOF_MISS_CNT_EN
    .missCntClr(clr),
    .missCnt(mcnt),
`endif
    .sendPacketArbiterReq(req),
    .sendPacketWEn(wen),
    .sendPacketPID(pid),
    .frameNum(fnum),
    .sofTimer(tmr),
    .sofSent(sent)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_timer = 0; m_frame = 0; m_miss = 0; m_pid = 0;
    m_req = 0; m_wen = 0; m_granted = 0;
  endfunction

  function automatic void model_step();
    bit ok;
    bit missed;
    int nt;
    ok = gnt && rdy;
    missed = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!sofEnable) begin
      m_timer = 0; m_req = 0; m_wen = 0; m_granted = 0;
    end else begin
      nt = (sofSyncEn && !m_req) ? (P - 1 - M) : ((m_timer + 1) % P);
      if (m_wen) begin
        m_wen = 0; m_req = 0; m_granted = 0;
        m_frame = (m_frame + 1) % 2048;
      end else if (!m_req) begin
        if (m_timer == P - 1 - M) m_req = 1;
      end else if (m_timer == P - 1) begin
        if (m_granted || ok) begin
          m_wen = 1;
          m_pid = lowSpeedMode ? 0 : 5;
        end else begin
          m_req = 0;
          missed = 1;
          m_frame = (m_frame + 1) % 2048;
        end
      end else if (ok) begin
        m_granted = 1;
      end
      m_timer = nt;
    end
    if (clr) m_miss = 0;
    else if (missed && m_miss < 255) m_miss++;
  endfunction

  task automatic check_model();
    chk("req", req, m_req);
    chk("wen", wen, m_wen);
    chk("sofSent", sent, m_wen);
    chk("frameNum", fnum, m_frame);
    chk("sofTimer", tmr, m_timer);
    if (m_wen) chk("pid", pid, m_pid);
`ifdef SOF_MISS_CNT_EN
    chk("missCnt", mcnt, m_miss);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One frame shortened by a sync pulse and lost for lack of grant: 12 edges, ends at timer 0.
  task automatic miss_frame(input bit clr_last);
    gnt = 0; sofSyncEn = 1;
    tick();
    sofSyncEn = 0;
    ticks(10);
    clr = clr_last;
    tick();
    clr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " req"}, req, 0);
    chk({tag, " wen"}, wen, 0);
    chk({tag, " sofSent"}, sent, 0);
    chk({tag, " pid"}, pid, 0);
    chk({tag, " frameNum"}, fnum, 0);
    chk({tag, " sofTimer"}, tmr, 0);
`ifdef SOF_MISS_CNT_EN
    chk({tag, " missCnt"}, mcnt, 0);
`endif
  endtask

  typedef struct {
    int n;
    bit en, ls, g, r;
    bit req, wen;
    int pid, timer, frame, miss;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{89, 1, 0, 1, 1, 0, 0, 0, 89, 0, 0};
    vecs[1]  = '{ 1, 1, 0, 1, 1, 1, 0, 0, 90, 0, 0};
    vecs[2]  = '{ 9, 1, 0, 1, 1, 1, 0, 0, 99, 0, 0};
    vecs[3]  = '{ 1, 1, 0, 1, 1, 1, 1, 5,  0, 0, 0};
    vecs[4]  = '{ 1, 1, 0, 1, 1, 0, 0, 0,  1, 1, 0};
    vecs[5]  = '{88, 1, 1, 1, 1, 0, 0, 0, 89, 1, 0};
    vecs[6]  = '{ 1, 1, 1, 1, 1, 1, 0, 0, 90, 1, 0};
    vecs[7]  = '{10, 1, 1, 1, 1, 1, 1, 0,  0, 1, 0};
    vecs[8]  = '{ 1, 1, 1, 1, 1, 0, 0, 0,  1, 2, 0};
    vecs[9]  = '{89, 1, 0, 0, 1, 1, 0, 0, 90, 2, 0};
    vecs[10] = '{ 9, 1, 0, 0, 1, 1, 0, 0, 99, 2, 0};
    vecs[11] = '{ 1, 1, 0, 1, 1, 1, 1, 5,  0, 2, 0};
    vecs[12] = '{ 1, 1, 0, 0, 1, 0, 0, 0,  1, 3, 0};
    vecs[13] = '{89, 1, 0, 0, 1, 1, 0, 0, 90, 3, 0};
    vecs[14] = '{ 9, 1, 0, 0, 1, 1, 0, 0, 99, 3, 0};
    vecs[15] = '{ 1, 1, 0, 0, 1, 0, 0, 0,  0, 4, 1};
    vecs[16] = '{ 1, 1, 0, 0, 1, 0, 0, 0,  1, 4, 1};

    model_reset();
    #1;
    check_all_zero("reset");
    ticks(2);
    rst = 0;

    // Basic, low-speed, late-grant and missed frames from reset.
    for (int v = 0; v < 17; v++) begin
      sofEnable = vecs[v].en; lowSpeedMode = vecs[v].ls;
      gnt = vecs[v].g; rdy = vecs[v].r;
      ticks(vecs[v].n);
      chk($sformatf("vec%0d req", v), req, vecs[v].req);
      chk($sformatf("vec%0d wen", v), wen, vecs[v].wen);
      chk($sformatf("vec%0d sofSent", v), sent, vecs[v].wen);
      chk($sformatf("vec%0d timer", v), tmr, vecs[v].timer);
      chk($sformatf("vec%0d frame", v), fnum, vecs[v].frame);
      if (vecs[v].wen) chk($sformatf("vec%0d pid", v), pid, vecs[v].pid);
`ifdef SOF_MISS_CNT_EN
      chk($sformatf("vec%0d missCnt", v), mcnt, vecs[v].miss);
`endif
      $display("vec %0d: timer=%0d req=%0d wen=%0d pid=%0h frame=%0d", v, tmr, req, wen, pid, fnum);
    end

    // Sync at timer 20 jumps to 89; request rises as the timer reaches 90.
    gnt = 0;
    ticks(19);
    chk("sync pre timer", tmr, 20);
    sofSyncEn = 1;
    tick();
    sofSyncEn = 0;
    chk("sync timer", tmr, 89);
    chk("sync req low", req, 0);
    tick();
    chk("sync timer+1", tmr, 90);
    chk("sync req high", req, 1);
    gnt = 1;
    ticks(10);
    chk("sync wen", wen, 1);
    chk("sync frame", fnum, 4);
    tick();
    chk("sync frame after", fnum, 5);
    $display("sync: frame sent, frameNum now %0d", fnum);

    // Disable while waiting for the boundary with the grant already held.
    ticks(94);
    chk("dis pre req", req, 1);
    chk("dis pre timer", tmr, 95);
    sofEnable = 0;
    tick();
    chk("dis req", req, 0);
    chk("dis timer", tmr, 0);
    chk("dis frame", fnum, 5);
    ticks(5);
    chk("dis wen", wen, 0);
    chk("dis frame held", fnum, 5);
    $display("disable: req=%0d timer=%0d frame=%0d", req, tmr, fnum);

    // Async reset between edges while waiting for the boundary.
    sofEnable = 1;
    ticks(95);
    chk("arst pre req", req, 1);
    #3;
    rst = 1;
    #1;
    check_all_zero("arst");
    model_reset();
    tick();
    rst = 0;
    ticks(90);
    chk("arst req", req, 1);
    chk("arst timer", tmr, 90);
    chk("arst frame", fnum, 0);
    ticks(10);
    chk("arst wen", wen, 1);
    chk("arst wen frame", fnum, 0);
    tick();
    $display("async reset: restarted, frameNum now %0d", fnum);

    // Randomised run, model checked every cycle.
    for (int i = 0; i < 5000; i++) begin
      sofSyncEn = ($urandom_range(0, 49) == 0);
      if (sofEnable) sofEnable = ($urandom_range(0, 299) != 0);
      else sofEnable = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) lowSpeedMode = !lowSpeedMode;
      gnt = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 199) == 0);
      tick();
      if (wen) $display("random: frame %0d written pid=%0h", fnum, pid);
    end
    sofSyncEn = 0; clr = 0; lowSpeedMode = 0; sofEnable = 1; rdy = 1; gnt = 0;

    // Miss counter saturation, clear, and clear winning over an increment.
    rst = 1;
    tick();
    rst = 0;
    for (int f = 0; f < 300; f++) miss_frame(1'b0);
    chk("sat frame", fnum, 300);
`ifdef SOF_MISS_CNT_EN
    chk("sat missCnt", mcnt, 255);
`endif
    clr = 1;
    tick();
    clr = 0;
`ifdef SOF_MISS_CNT_EN
    chk("clr missCnt", mcnt, 0);
`endif
    miss_frame(1'b1);
`ifdef SOF_MISS_CNT_EN
    chk("clr wins missCnt", mcnt, 0);
`endif
    chk("clr wins frame", fnum, 301);
    $display("miss counter: saturation and clear done, frameNum=%0d", fnum);

    // Frame number wrap 2047 -> 0.
    rst = 1;
    tick();
    rst = 0;
    for (int f = 0; f < 2047; f++) miss_frame(1'b0);
    chk("wrap frame 2047", fnum, 2047);
    miss_frame(1'b0);
    chk("wrap frame 0", fnum, 0);
    chk("wrap timer", tmr, 0);
    $display("wrap: frameNum=%0d", fnum);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
